// File: rtl/mem_drop_ctrl.sv
// Memory-response drop sequencer: tracks in-flight requests, converts a squash
// pulse into the exact number of response drops, and stalls requests at the limit.
module mem_drop_ctrl #(
  parameter int p_max_outstanding = 4,
  parameter int p_cnt_nbits       = 3,
  parameter int p_stat_nbits      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    squash,
  input  logic                    proc_req_val,
  output logic                    proc_req_rdy,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  input  logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    drop,
  output logic [p_cnt_nbits-1:0]  outstanding,
  output logic                    draining,
  output logic [p_stat_nbits-1:0] drop_total,
  output logic                    err_underflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [p_cnt_nbits-1:0]  out_cnt_q, out_cnt_d;
  logic [p_cnt_nbits-1:0]  drop_cnt_q, drop_cnt_d;
  logic [p_stat_nbits-1:0] drop_total_q, drop_total_d;
  logic                    err_q, err_d;

  logic full;
  logic req_go;
  logic resp_go;
  logic underflow;

  // Gating uses only the registered count, so a same-cycle response never
  // lifts the stall and there is no path from resp_* to proc_req_rdy.
  always_comb begin
    full         = (out_cnt_q == p_cnt_nbits'(p_max_outstanding));
    mem_req_val  = proc_req_val && !full;
    proc_req_rdy = mem_req_rdy && !full;
    req_go       = mem_req_val && mem_req_rdy;
    resp_go      = resp_val && resp_rdy;
    underflow    = resp_go && (out_cnt_q == '0) && !req_go;
    drop         = squash || (drop_cnt_q != '0);
  end

  always_comb begin
    out_cnt_d    = out_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    drop_total_d = drop_total_q;
    err_d        = err_q | underflow;

    if (!underflow) begin
      out_cnt_d = out_cnt_q + p_cnt_nbits'(req_go) - p_cnt_nbits'(resp_go);
    end

    // A squash re-targets the drain at everything still in flight after this
    // cycle, including a request issued alongside it.
    if (squash) begin
      drop_cnt_d = out_cnt_d;
    end else if (resp_go && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    if (resp_go && drop && (drop_total_q != '1)) begin
      drop_total_d = drop_total_q + 1'b1;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (drop_cnt_d != '0) begin
      state_d = S_DRAIN;
    end else if (out_cnt_d != '0) begin
      state_d = S_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      drop_total_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_total_q <= drop_total_d;
      err_q        <= err_d;
    end
  end

  assign outstanding   = out_cnt_q;
  assign draining      = (state_q == S_DRAIN);
  assign drop_total    = drop_total_q;
  assign err_underflow = err_q;

endmodule

// File: doc/mem_drop_ctrl.md
Name: mem_drop_ctrl

Overview:
- Sequences the drop unit on the processor's memory-response path.
- Counts in-flight memory requests and turns a squash pulse into exactly the right number of response drops. It holds the drop level until every squashed request's response has been swallowed.
- Gates new memory requests when the in-flight limit is reached.
- Sits between the fetch/memory stage control, the memory request port, and the drop unit in front of the response queue.

Parameters:
- p_max_outstanding, 4: maximum in-flight requests (1..255).
- p_cnt_nbits, 3: counter width; must satisfy 2^p_cnt_nbits > p_max_outstanding.
- p_stat_nbits, 16: width of the saturating dropped-response statistic counter.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- squash  input  1  one-cycle pulse; discard responses of all requests issued up to and including this cycle
- proc_req_val  input  1  processor request valid
- proc_req_rdy  output  1  processor request ready (gated)
- mem_req_val  output  1  request valid to memory
- mem_req_rdy  input  1  memory ready
- resp_val  input  1  response valid at drop-unit input
- resp_rdy  input  1  drop-unit input ready (observed only)
- drop  output  1  drop level to drop unit
- outstanding  output  p_cnt_nbits  current in-flight count
- draining  output  1  high while squashed responses remain
- drop_total  output  p_stat_nbits  saturating count of dropped responses
- err_underflow  output  1  sticky: response accepted with no request outstanding

Behaviour:
- Reset: out_cnt=0, drop_cnt=0, drop_total=0, err_underflow=0, state IDLE. Reset mid-drain discards all pending drops.
- req_go = mem_req_val && mem_req_rdy. resp_go = resp_val && resp_rdy.
- Request gating: full = (out_cnt == p_max_outstanding).
  - mem_req_val = proc_req_val && !full.
  - proc_req_rdy = mem_req_rdy && !full.
- A response retiring in the same cycle does not lift the full stall.
- Request gating is independent of draining. New requests are accepted during a drain and their responses pass.
- out_cnt next = out_cnt + req_go - resp_go, with no wrap.
- If resp_go occurs while out_cnt==0 and !req_go: out_cnt stays 0, drop_cnt is untouched, and err_underflow sets until reset.
- drop = squash || (drop_cnt != 0). The output is combinational in squash, so a response accepted in the squash cycle is dropped.
- drop_cnt next:
  - squash: out_cnt + req_go - resp_go, i.e. every request outstanding after this cycle, including one issued in this cycle.
  - otherwise: drop_cnt - (resp_go && drop_cnt != 0).
- A squash while draining re-evaluates drop_cnt to all in-flight requests.
- Invariant: drop_cnt <= out_cnt.
- The drop level falls in the cycle after the last squashed response is accepted. The drop unit therefore never drops a post-squash response.
- drop_total increments on resp_go && drop and saturates at all-ones.
- State machine (drives draining; states are encoded from the counters):
  - IDLE: out_cnt==0 and drop_cnt==0.
  - BUSY: out_cnt>0 and drop_cnt==0.
  - DRAIN: drop_cnt>0.
  - Transitions follow the next-count values. Squash with nothing in flight goes IDLE->IDLE. draining = (state==DRAIN).
- No combinational path from resp_val/resp_rdy to proc_req_rdy.

Test Plan:
- Issue 3 requests, no squash, return 3 responses:
  - outstanding goes 1,2,3,2,1,0.
  - drop stays 0; drop_total=0.
- Issue 3 requests, squash in a cycle with no req/resp, return 3 responses:
  - drop high for exactly those 3 accepts, falls the next cycle.
  - drop_total=3; a 4th request's response passes.
- Squash in the same cycle as a req_go and a resp_go with out_cnt=2:
  - that response is dropped; drop_cnt=2.
  - the next 2 responses are dropped.
- Fill to 4 in flight:
  - proc_req_rdy=0 and mem_req_val=0 while proc_req_val=1.
  - one response re-opens ready the next cycle.
- Squash with 2 in flight, issue 1 new request during the drain, then squash again before any response:
  - drop_cnt=3; all 3 responses are dropped.
- Assert resp_val&&resp_rdy with outstanding=0:
  - err_underflow=1 sticky; outstanding stays 0.
  - reset during a drain with drop_cnt=2: drop=0 in the cycle after reset.
